// File: rtl/cve2_pkg.sv
// Shared types for the cve2 core slice: power-controller state encoding and
// the sizing helper for its shared DRAIN/WAKE down-counter.
package cve2_pkg;

   typedef enum logic [2:0] {
      PWR_OFF   = 3'd0,
      PWR_RUN   = 3'd1,
      PWR_DRAIN = 3'd2,
      PWR_SLEEP = 3'd3,
      PWR_WAKE  = 3'd4
   } pwr_state_e;

   // Counter must hold both IdleHyst-1 and WakeDelay-1; never narrower than 1 bit.
   function automatic int unsigned pwr_cnt_width(input int unsigned idle_hyst,
                                                 input int unsigned wake_delay);
      int unsigned m;
      m = 2;
      if (idle_hyst > m) m = idle_hyst;
      if (wake_delay > m) m = wake_delay;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/cve2_clock_gate.sv
// Latch-based clock gate: enable is captured while the clock is low, so
// enable changes during the high phase cannot glitch the gated clock.
module cve2_clock_gate (
   input  logic clk_i,
   input  logic en_i,
   input  logic scan_cg_en_i,
   output logic clk_o
);

   logic en_latch;

   always_latch begin
      if (!clk_i) begin
         en_latch <= en_i | scan_cg_en_i;
      end
   end

   assign clk_o = clk_i & en_latch;

endmodule

// File: rtl/cve2_pwr_ctrl.sv
// Power/clock-gating controller for the cve2 core: sticky fetch enable, idle
// hysteresis, maskable wake sources, wake settling delay and sleep counter.
module cve2_pwr_ctrl
   import cve2_pkg::*;
#(
   parameter int unsigned NumWake   = 4,
   parameter int unsigned IdleHyst  = 2,
   parameter int unsigned WakeDelay = 0,
   parameter int unsigned CntWidth  = 32
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                test_en_i,
   input  logic                fetch_enable_i,
   input  logic                core_busy_i,
   input  logic                debug_req_i,
   input  logic                irq_pending_i,
   input  logic                irq_nm_i,
   input  logic [NumWake-1:0]  wake_i,
   input  logic [NumWake-1:0]  wake_en_i,
   input  logic                sleep_cnt_clr_i,
   output logic                clk_o,
   output logic                fetch_enable_o,
   output logic                core_sleep_o,
   output logic [2:0]          state_o,
   output logic [CntWidth-1:0] sleep_cycles_o
);

   localparam int unsigned CW = pwr_cnt_width(IdleHyst, WakeDelay);
   localparam logic [CW-1:0] HystLoad = CW'((IdleHyst  > 0) ? IdleHyst  - 1 : 0);
   localparam logic [CW-1:0] WakeLoad = CW'((WakeDelay > 0) ? WakeDelay - 1 : 0);

   if (NumWake < 1) begin : gen_bad_num_wake
      $error("cve2_pwr_ctrl: NumWake must be >= 1");
   end
   if (CntWidth < 1) begin : gen_bad_cnt_width
      $error("cve2_pwr_ctrl: CntWidth must be >= 1");
   end

   pwr_state_e          state_q;
   logic                fetch_q;
   logic                busy_q;
   logic [CW-1:0]       cnt_q;
   logic [CntWidth-1:0] sleep_cnt_q;
   logic                wake_any;
   logic                idle;
   logic                clock_en;
   logic                core_sleep;

   assign wake_any = debug_req_i | irq_pending_i | irq_nm_i | (|(wake_i & wake_en_i));
   assign idle     = ~busy_q & ~wake_any;

   // Only the SLEEP term is combinational on wake_any; the latch gate absorbs it.
   always_comb begin
      clock_en = 1'b0;
      unique case (state_q)
         PWR_RUN, PWR_DRAIN: clock_en = 1'b1;
         PWR_SLEEP:          clock_en = (WakeDelay == 0) && wake_any;
         default:            clock_en = 1'b0;
      endcase
   end

   assign core_sleep = ((state_q == PWR_SLEEP) || (state_q == PWR_WAKE)) && !clock_en;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= PWR_OFF;
         fetch_q <= 1'b0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         busy_q <= core_busy_i;
         if (fetch_enable_i) begin
            fetch_q <= 1'b1;
         end
         unique case (state_q)
            PWR_OFF: begin
               if (fetch_q) state_q <= PWR_RUN;
            end
            PWR_RUN: begin
               if (idle) begin
                  if (IdleHyst == 0) begin
                     state_q <= PWR_SLEEP;
                  end else begin
                     state_q <= PWR_DRAIN;
                     cnt_q   <= HystLoad;
                  end
               end
            end
            PWR_DRAIN: begin
               if (!idle) begin
                  state_q <= PWR_RUN;
               end else if (cnt_q == '0) begin
                  state_q <= PWR_SLEEP;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            PWR_SLEEP: begin
               if (wake_any) begin
                  if (WakeDelay == 0) begin
                     state_q <= PWR_RUN;
                  end else begin
                     state_q <= PWR_WAKE;
                     cnt_q   <= WakeLoad;
                  end
               end
            end
            PWR_WAKE: begin
               if (cnt_q == '0) begin
                  state_q <= PWR_RUN;
               end else begin
                  cnt_q <= cnt_q - CW'(1);
               end
            end
            default: state_q <= PWR_OFF;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sleep_cnt_q <= '0;
      end else if (sleep_cnt_clr_i) begin
         sleep_cnt_q <= '0;
      end else if (core_sleep && (sleep_cnt_q != '1)) begin
         sleep_cnt_q <= sleep_cnt_q + CntWidth'(1);
      end
   end

   cve2_clock_gate u_clock_gate (
      .clk_i        (clk_i),
      .en_i         (clock_en),
      .scan_cg_en_i (test_en_i),
      .clk_o        (clk_o)
   );

   assign fetch_enable_o = fetch_q;
   assign core_sleep_o   = core_sleep;
   assign state_o        = state_q;
   assign sleep_cycles_o = sleep_cnt_q;

endmodule

// File: tb/tb_cve2_pwr_ctrl.sv
// Directed bench: two controllers share stimulus; A has hysteresis and
// combinational wake, B gates immediately and uses a 3-cycle wake delay.
module tb_cve2_pwr_ctrl;

   localparam logic [2:0] S_OFF = 3'd0, S_RUN = 3'd1, S_DRAIN = 3'd2,
                          S_SLEEP = 3'd3, S_WAKE = 3'd4;

   logic       clk = 1'b0, rst_n = 1'b0, test_en = 1'b0, fe_in = 1'b0;
   logic       busy = 1'b1, dbg = 1'b0, irqp = 1'b0, irqnm = 1'b0, clr = 1'b0;
   logic [3:0] wake = '0, wake_en = '0;

   logic       a_clk, a_fe, a_cs, b_clk, b_fe, b_cs;
   logic [2:0] a_state, b_state;
   logic [3:0] a_sc;
   logic [7:0] b_sc;

   int checks = 0, failures = 0, cyc = 0;

   always #5 clk = ~clk;

   cve2_pwr_ctrl #(.NumWake(4), .IdleHyst(2), .WakeDelay(0), .CntWidth(4)) dut_a (
      .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en), .fetch_enable_i(fe_in),
      .core_busy_i(busy), .debug_req_i(dbg), .irq_pending_i(irqp), .irq_nm_i(irqnm),
      .wake_i(wake), .wake_en_i(wake_en), .sleep_cnt_clr_i(clr),
      .clk_o(a_clk), .fetch_enable_o(a_fe), .core_sleep_o(a_cs),
      .state_o(a_state), .sleep_cycles_o(a_sc));

   cve2_pwr_ctrl #(.NumWake(4), .IdleHyst(0), .WakeDelay(3), .CntWidth(8)) dut_b (
      .clk_i(clk), .rst_ni(rst_n), .test_en_i(test_en), .fetch_enable_i(fe_in),
      .core_busy_i(busy), .debug_req_i(dbg), .irq_pending_i(irqp), .irq_nm_i(irqnm),
      .wake_i(wake), .wake_en_i(wake_en), .sleep_cnt_clr_i(clr),
      .clk_o(b_clk), .fetch_enable_o(b_fe), .core_sleep_o(b_cs),
      .state_o(b_state), .sleep_cycles_o(b_sc));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, got, exp);
      end
   endtask

   // Cycle k starts just after the k-th rising edge; clk_o sampled here
   // shows whether the gate let that edge through.
   task automatic tick_to(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
         cyc++;
      end
   endtask

   initial begin
      tick_to(1);
      check("rst_a_state", 32'(a_state), 32'(S_OFF));
      check("rst_b_state", 32'(b_state), 32'(S_OFF));
      check("rst_a_fe", 32'(a_fe), 0);
      check("rst_a_cs", 32'(a_cs), 0);
      check("rst_a_sc", 32'(a_sc), 0);
      check("rst_a_clk", 32'(a_clk), 0);
      rst_n = 1'b1;

      tick_to(3); fe_in = 1'b1;
      tick_to(4); fe_in = 1'b0;
      check("fe_a_n1", 32'(a_fe), 1);
      check("fe_b_n1", 32'(b_fe), 1);
      check("a_off_n1", 32'(a_state), 32'(S_OFF));
      tick_to(5);
      check("a_run_n2", 32'(a_state), 32'(S_RUN));
      check("b_run_n2", 32'(b_state), 32'(S_RUN));
      check("a_clk_pre", 32'(a_clk), 0);
      tick_to(6);
      check("a_clk_run", 32'(a_clk), 1);
      check("b_clk_run", 32'(b_clk), 1);

      tick_to(8); busy = 1'b0;
      check("fe_sticky", 32'(a_fe), 1);
      tick_to(10);
      check("a_drain1", 32'(a_state), 32'(S_DRAIN));
      check("b_sleep_h0", 32'(b_state), 32'(S_SLEEP));
      check("b_cs_sleep", 32'(b_cs), 1);
      check("a_cs_drain", 32'(a_cs), 0);
      tick_to(11);
      check("a_drain2", 32'(a_state), 32'(S_DRAIN));
      tick_to(12);
      check("a_sleep_h2", 32'(a_state), 32'(S_SLEEP));
      check("a_cs_sleep", 32'(a_cs), 1);

      tick_to(13); wake = 4'b0100;
      tick_to(14);
      check("a_clk_gated", 32'(a_clk), 0);
      check("b_clk_gated", 32'(b_clk), 0);
      tick_to(15);
      check("a_masked", 32'(a_state), 32'(S_SLEEP));
      check("b_masked", 32'(b_state), 32'(S_SLEEP));
      check("a_sc15", 32'(a_sc), 3);
      check("b_sc15", 32'(b_sc), 5);

      tick_to(35);
      check("a_sc_sat", 32'(a_sc), 15);
      check("b_sc35", 32'(b_sc), 25);
      clr = 1'b1;
      tick_to(36);
      check("a_sc_clr", 32'(a_sc), 0);
      check("b_sc_clr", 32'(b_sc), 0);
      clr = 1'b0;
      tick_to(37);
      check("a_sc37", 32'(a_sc), 1);
      check("b_sc37", 32'(b_sc), 1);
      wake_en = 4'b0100;
      #1;
      check("a_cs_comb_wake", 32'(a_cs), 0);
      check("b_cs_delayed", 32'(b_cs), 1);

      tick_to(38);
      check("a_run_wake", 32'(a_state), 32'(S_RUN));
      check("a_clk_wake", 32'(a_clk), 1);
      check("a_sc_hold", 32'(a_sc), 1);
      check("b_wake", 32'(b_state), 32'(S_WAKE));
      check("b_clk_wake", 32'(b_clk), 0);
      wake_en = 4'b0000;
      tick_to(40);
      check("a_drain_last", 32'(a_state), 32'(S_DRAIN));
      check("b_wake_noabort", 32'(b_state), 32'(S_WAKE));
      irqp = 1'b1;
      tick_to(41);
      check("a_drain_wake", 32'(a_state), 32'(S_RUN));
      check("b_run_d3", 32'(b_state), 32'(S_RUN));
      check("a_clk_nogap", 32'(a_clk), 1);
      check("b_clk_d3", 32'(b_clk), 0);
      check("a_sc41", 32'(a_sc), 1);
      check("b_sc41", 32'(b_sc), 5);
      tick_to(42);
      check("b_clk_run2", 32'(b_clk), 1);
      irqp = 1'b0;

      tick_to(43); busy = 1'b1;
      check("b_sleep2", 32'(b_state), 32'(S_SLEEP));
      check("a_drain_b1", 32'(a_state), 32'(S_DRAIN));
      tick_to(44);
      check("a_drain_b2", 32'(a_state), 32'(S_DRAIN));
      tick_to(45);
      check("a_busy_run", 32'(a_state), 32'(S_RUN));
      check("a_clk_busy", 32'(a_clk), 1);
      check("b_busy_ign", 32'(b_state), 32'(S_SLEEP));
      check("b_sc45", 32'(b_sc), 7);
      test_en = 1'b1;
      tick_to(46);
      check("b_clk_scan", 32'(b_clk), 1);
      check("b_scan_fsm", 32'(b_state), 32'(S_SLEEP));
      test_en = 1'b0;
      tick_to(47);
      check("b_clk_scan_off", 32'(b_clk), 0);
      irqnm = 1'b1;
      tick_to(48);
      check("b_wake_nm", 32'(b_state), 32'(S_WAKE));
      irqnm = 1'b0;

      tick_to(49);
      check("b_wake_pre_rst", 32'(b_state), 32'(S_WAKE));
      rst_n = 1'b0;
      #1;
      check("b_rst_state", 32'(b_state), 32'(S_OFF));
      check("b_rst_clk", 32'(b_clk), 0);
      check("b_rst_fe", 32'(b_fe), 0);
      check("b_rst_cs", 32'(b_cs), 0);
      check("b_rst_sc", 32'(b_sc), 0);
      check("a_rst_state", 32'(a_state), 32'(S_OFF));
      check("a_rst_fe", 32'(a_fe), 0);
      tick_to(50);
      check("a_rst_clk", 32'(a_clk), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
